// File: rtl/rs_dec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_dec_ctrl_if
// Description : Handshake and status bundle between the RS decoder frame
//               sequencer and its surroundings (beat source, syndrome
//               accumulator, BM engine, Chien engine, status sink).
//   in_valid/in_ready/in_sop/in_eop  codeword beat handshake
//   synd_clr/synd_en/synd_mask       syndrome accumulator control
//   synd_zero                        all syndromes zero
//   bm_start/bm_done/bm_fail/bm_deg  Berlekamp-Massey handshake
//   chien_start/chien_done/roots     Chien search handshake
//   frm_done/frm_status/frm_err_cnt  per-frame result
//   modport master : sequencer view
//   modport slave  : datapath / environment view
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_dec_ctrl_if #(
   parameter int BUS_WIDTH_IN_SYMB = 4,
   parameter int DW                = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic                         in_sop;
   logic                         in_eop;
   logic                         synd_clr;
   logic                         synd_en;
   logic [BUS_WIDTH_IN_SYMB-1:0] synd_mask;
   logic                         synd_zero;
   logic                         bm_start;
   logic                         bm_done;
   logic                         bm_fail;
   logic [DW-1:0]                bm_deg;
   logic                         chien_start;
   logic                         chien_done;
   logic [DW-1:0]                chien_roots;
   logic                         frm_done;
   logic [2:0]                   frm_status;
   logic [DW-1:0]                frm_err_cnt;

   modport master (
      input  in_valid, in_sop, in_eop, synd_zero,
             bm_done, bm_fail, bm_deg, chien_done, chien_roots,
      output in_ready, synd_clr, synd_en, synd_mask,
             bm_start, chien_start, frm_done, frm_status, frm_err_cnt
   );

   modport slave (
      output in_valid, in_sop, in_eop, synd_zero,
             bm_done, bm_fail, bm_deg, chien_done, chien_roots,
      input  in_ready, synd_clr, synd_en, synd_mask,
             bm_start, chien_start, frm_done, frm_status, frm_err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rs_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rs_dec_ctrl
// Description : Frame sequencer for an RS(N_LEN,K_LEN) decoder. Receives a
//               codeword as beats of BUS_WIDTH_IN_SYMB symbols while steering
//               the syndrome accumulator, then runs BM and Chien search via
//               start/done handshakes and reports one status per frame.
//   clk  : clock
//   rst  : synchronous reset, active high
//   bus  : rs_dec_ctrl_if.master (beat handshake, syndrome control,
//          BM/Chien handshakes, frame result)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_dec_ctrl #(
   parameter int N_LEN             = 255,
   parameter int K_LEN             = 239,
   parameter int BUS_WIDTH_IN_SYMB = 4,
   parameter int SYND_LAT          = 2,
   parameter int TMO_CYC           = 1024
) (
   input wire            clk,
   input wire            rst,
   rs_dec_ctrl_if.master bus
);
   localparam int T_VAL     = (N_LEN - K_LEN) / 2;
   localparam int BEATS     = (N_LEN + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB;
   localparam int LAST_SYMS = N_LEN - (BEATS - 1) * BUS_WIDTH_IN_SYMB;
   localparam int DW        = $clog2(T_VAL + 1);
   localparam int BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WDW       = $clog2(TMO_CYC + 1);

   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [WDW-1:0] SYND_LAST = WDW'(SYND_LAT - 1);
   localparam logic [WDW-1:0] TMO_LAST  = WDW'(TMO_CYC - 1);

   localparam logic [BUS_WIDTH_IN_SYMB-1:0] MASK_FULL = '1;
   localparam logic [BUS_WIDTH_IN_SYMB-1:0] MASK_LAST =
      MASK_FULL >> (BUS_WIDTH_IN_SYMB - LAST_SYMS);

   localparam logic [2:0] ST_OK        = 3'd0;
   localparam logic [2:0] ST_CORRECTED = 3'd1;
   localparam logic [2:0] ST_UNCORR    = 3'd2;
   localparam logic [2:0] ST_FRAME_ERR = 3'd3;
   localparam logic [2:0] ST_TIMEOUT   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RECV      = 3'd1,
      S_SYND_WAIT = 3'd2,
      S_BM        = 3'd3,
      S_CHIEN     = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [WDW-1:0]         wdog_q, wdog_d;   // also times the syndrome latency
   logic [DW-1:0]          deg_q, deg_d;
   logic                   in_ready_q, in_ready_d;
   logic                   bm_start_q, bm_start_d;
   logic                   chien_start_q, chien_start_d;
   logic                   frm_done_q, frm_done_d;
   logic [2:0]             status_q, status_d;
   logic [DW-1:0]          err_cnt_q, err_cnt_d;

   logic                   in_ready;
   logic                   accept;
   logic                   is_last;
   logic                   synd_clr;
   logic                   synd_en;
   logic [BUS_WIDTH_IN_SYMB-1:0] synd_mask;

   // The ready flop only settles one edge after reset; masking with rst keeps
   // the handshake closed for every cycle reset is asserted.
   assign in_ready = in_ready_q & ~rst;
   assign accept   = bus.in_valid & in_ready;
   assign is_last  = (beat_cnt_q == LAST_BEAT);

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      wdog_d        = wdog_q;
      deg_d         = deg_q;
      status_d      = status_q;
      err_cnt_d     = err_cnt_q;
      bm_start_d    = 1'b0;
      chien_start_d = 1'b0;
      synd_clr      = 1'b0;
      synd_en       = 1'b0;
      synd_mask     = '0;

      case (state_q)
         S_IDLE: begin
            // Beats without sop are dropped here while hunting for a frame.
            if (accept && bus.in_sop) begin
               if (bus.in_eop) begin
                  state_d   = S_DONE;
                  status_d  = ST_FRAME_ERR;
                  err_cnt_d = '0;
               end else begin
                  synd_clr   = 1'b1;
                  synd_en    = 1'b1;
                  synd_mask  = MASK_FULL;
                  beat_cnt_d = BCW'(1);
                  state_d    = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (accept) begin
               // eop must coincide exactly with the final beat; a framing
               // violation is not folded into the syndromes.
               if (bus.in_sop || (bus.in_eop != is_last)) begin
                  beat_cnt_d = '0;
                  state_d    = S_DONE;
                  status_d   = ST_FRAME_ERR;
                  err_cnt_d  = '0;
               end else begin
                  synd_en   = 1'b1;
                  synd_mask = is_last ? MASK_LAST : MASK_FULL;
                  if (is_last) begin
                     beat_cnt_d = '0;
                     wdog_d     = '0;
                     state_d    = S_SYND_WAIT;
                  end else begin
                     beat_cnt_d = beat_cnt_q + 1'b1;
                  end
               end
            end
         end

         S_SYND_WAIT: begin
            if (wdog_q == SYND_LAST) begin
               wdog_d = '0;
               if (bus.synd_zero) begin
                  state_d   = S_DONE;
                  status_d  = ST_OK;
                  err_cnt_d = '0;
               end else begin
                  bm_start_d = 1'b1;
                  state_d    = S_BM;
               end
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         S_BM: begin
            // A done arriving on the final watchdog cycle takes priority.
            if (bus.bm_done) begin
               wdog_d = '0;
               if (bus.bm_fail) begin
                  state_d   = S_DONE;
                  status_d  = ST_UNCORR;
                  err_cnt_d = '0;
               end else begin
                  deg_d         = bus.bm_deg;
                  chien_start_d = 1'b1;
                  state_d       = S_CHIEN;
               end
            end else if (wdog_q == TMO_LAST) begin
               state_d   = S_DONE;
               status_d  = ST_TIMEOUT;
               err_cnt_d = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         S_CHIEN: begin
            if (bus.chien_done) begin
               wdog_d  = '0;
               state_d = S_DONE;
               // Root count must match the locator degree to trust the fix.
               if (bus.chien_roots == deg_q) begin
                  status_d  = ST_CORRECTED;
                  err_cnt_d = deg_q;
               end else begin
                  status_d  = ST_UNCORR;
                  err_cnt_d = '0;
               end
            end else if (wdog_q == TMO_LAST) begin
               state_d   = S_DONE;
               status_d  = ST_TIMEOUT;
               err_cnt_d = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         S_DONE: begin
            wdog_d  = '0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      frm_done_d = (state_d == S_DONE);
      in_ready_d = (state_d == S_IDLE) || (state_d == S_RECV);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         beat_cnt_q    <= '0;
         wdog_q        <= '0;
         deg_q         <= '0;
         in_ready_q    <= 1'b0;
         bm_start_q    <= 1'b0;
         chien_start_q <= 1'b0;
         frm_done_q    <= 1'b0;
         status_q      <= 3'd0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         wdog_q        <= wdog_d;
         deg_q         <= deg_d;
         in_ready_q    <= in_ready_d;
         bm_start_q    <= bm_start_d;
         chien_start_q <= chien_start_d;
         frm_done_q    <= frm_done_d;
         status_q      <= status_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.synd_clr    = synd_clr;
   assign bus.synd_en     = synd_en;
   assign bus.synd_mask   = synd_mask;
   assign bus.bm_start    = bm_start_q;
   assign bus.chien_start = chien_start_q;
   assign bus.frm_done    = frm_done_q;
   assign bus.frm_status  = status_q;
   assign bus.frm_err_cnt = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_rs_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_dec_ctrl
// Description : Directed self-checking bench for rs_dec_ctrl (RS(255,239),
//               4 symbols per beat, SYND_LAT 2, TMO_CYC 1024).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_dec_ctrl;
   localparam int BEATS = 64;

   logic clk;
   logic rst;

   rs_dec_ctrl_if #(.BUS_WIDTH_IN_SYMB(4), .DW(4)) bus ();

   rs_dec_ctrl #(
      .N_LEN(255), .K_LEN(239), .BUS_WIDTH_IN_SYMB(4),
      .SYND_LAT(2), .TMO_CYC(1024)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec, n_mis;
   int n_en, n_full, n_last, n_bad, n_clr, n_bms, n_chs, n_done;
   int b_en, b_full, b_last, b_bad, b_clr, b_bms, b_chs, b_done;

   // Event counters sampled mid low phase, after inputs have settled.
   initial begin
      n_en = 0; n_full = 0; n_last = 0; n_bad = 0;
      n_clr = 0; n_bms = 0; n_chs = 0; n_done = 0;
      forever begin
         @(negedge clk);
         #2;
         if (bus.synd_en) begin
            n_en++;
            if (bus.synd_mask == 4'b1111)      n_full++;
            else if (bus.synd_mask == 4'b0111) n_last++;
            else                               n_bad++;
         end else if (bus.synd_mask != 4'b0000 || bus.synd_clr) begin
            n_bad++;
         end
         if (bus.synd_clr)    n_clr++;
         if (bus.bm_start)    n_bms++;
         if (bus.chien_start) n_chs++;
         if (bus.frm_done)    n_done++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_en = n_en; b_full = n_full; b_last = n_last; b_bad = n_bad;
      b_clr = n_clr; b_bms = n_bms; b_chs = n_chs; b_done = n_done;
   endtask

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_sop     = 1'b0;
      bus.in_eop     = 1'b0;
      bus.bm_done    = 1'b0;
      bus.chien_done = 1'b0;
   endtask

   // Sends beats from beat 0 (sop) up to the eop beat or the first beat that
   // breaks framing; gap_every > 0 inserts an idle cycle before every Nth beat.
   task automatic send_frame(input int eop_at, input int sop_at, input int gap_every);
      int tries;
      bit bad;
      for (int i = 0; i < BEATS; i++) begin
         bad = ((i == sop_at) && (i != 0)) || ((i == eop_at) && (eop_at != BEATS - 1));
         if (gap_every > 0 && i > 0 && (i % gap_every) == 0) begin
            @(negedge clk);
            idle();
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_sop   = (i == 0) || (i == sop_at);
         bus.in_eop   = (i == eop_at);
         #3;
         tries = 0;
         while (!bus.in_ready && tries < 20) begin
            @(negedge clk);
            #3;
            tries++;
         end
         if (!bus.in_ready) begin
            check("beat_ready", {31'd0, bus.in_ready}, 32'd1);
            idle();
            return;
         end
         if (bad) begin
            check("bad_beat_no_en", {31'd0, bus.synd_en}, 32'd0);
            return;
         end
         if (i == eop_at) return;
      end
   endtask

   task automatic wait_done(input int bound, output int c);
      c = 0;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         idle();
         #3;
         if (bus.frm_done) begin
            c = i;
            return;
         end
      end
   endtask

   task automatic wait_bm(input int bound, output int c);
      c = 0;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         idle();
         #3;
         if (bus.bm_start) begin
            c = i;
            return;
         end
      end
   endtask

   // Called mid-cycle; pulses bm_done d cycles later and returns one cycle on.
   task automatic pulse_bm(input int d, input logic fail, input logic [3:0] deg);
      repeat (d) @(negedge clk);
      bus.bm_done = 1'b1;
      bus.bm_fail = fail;
      bus.bm_deg  = deg;
      @(negedge clk);
      bus.bm_done = 1'b0;
      #3;
   endtask

   task automatic pulse_chien(input int d, input logic [3:0] roots);
      repeat (d) @(negedge clk);
      bus.chien_done  = 1'b1;
      bus.chien_roots = roots;
      @(negedge clk);
      bus.chien_done = 1'b0;
      #3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int c;
      n_vec = 0;
      n_mis = 0;
      rst = 1'b1;
      idle();
      bus.synd_zero   = 1'b0;
      bus.bm_fail     = 1'b0;
      bus.bm_deg      = 4'd0;
      bus.chien_roots = 4'd0;

      // ---------------- reset, with a sop beat presented --------------------
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sop   = 1'b1;
      @(negedge clk);
      #3;
      check("rst_in_ready",    {31'd0, bus.in_ready},    32'd0);
      check("rst_synd_en",     {31'd0, bus.synd_en},     32'd0);
      check("rst_synd_clr",    {31'd0, bus.synd_clr},    32'd0);
      check("rst_synd_mask",   {28'd0, bus.synd_mask},   32'd0);
      check("rst_bm_start",    {31'd0, bus.bm_start},    32'd0);
      check("rst_chien_start", {31'd0, bus.chien_start}, 32'd0);
      check("rst_frm_done",    {31'd0, bus.frm_done},    32'd0);
      check("rst_frm_status",  {29'd0, bus.frm_status},  32'd0);
      check("rst_frm_err_cnt", {28'd0, bus.frm_err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      @(negedge clk);
      #3;
      check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // ---------------- 1: clean frame -> OK --------------------------------
      bus.synd_zero = 1'b1;
      snap();
      send_frame(63, -1, 0);
      wait_done(10, c);
      check("t1_latency", c, 32'd3);
      check("t1_status",  {29'd0, bus.frm_status},  32'd0);
      check("t1_err_cnt", {28'd0, bus.frm_err_cnt}, 32'd0);
      check("t1_clr_cnt",  n_clr  - b_clr,  32'd1);
      check("t1_en_cnt",   n_en   - b_en,   32'd64);
      check("t1_full_cnt", n_full - b_full, 32'd63);
      check("t1_last_cnt", n_last - b_last, 32'd1);
      check("t1_bad_mask", n_bad  - b_bad,  32'd0);
      check("t1_bm_start", n_bms  - b_bms,  32'd0);
      check("t1_done_cnt", n_done - b_done, 32'd1);

      // ---------------- 2: BM deg 3, Chien 3 roots -> CORRECTED -------------
      bus.synd_zero = 1'b0;
      snap();
      send_frame(63, -1, 0);
      wait_bm(10, c);
      check("t2_bm_latency", c, 32'd3);
      pulse_bm(2, 1'b0, 4'd3);
      check("t2_chien_start", {31'd0, bus.chien_start}, 32'd1);
      check("t2_no_early_done", {31'd0, bus.frm_done}, 32'd0);
      pulse_chien(3, 4'd3);
      check("t2_frm_done", {31'd0, bus.frm_done},    32'd1);
      check("t2_status",   {29'd0, bus.frm_status},  32'd1);
      check("t2_err_cnt",  {28'd0, bus.frm_err_cnt}, 32'd3);
      check("t2_bm_pulses",    n_bms - b_bms, 32'd1);
      check("t2_chien_pulses", n_chs - b_chs, 32'd1);
      repeat (3) begin
         @(negedge clk);
         idle();
      end
      #3;
      check("t2_hold_done",   {31'd0, bus.frm_done},    32'd0);
      check("t2_hold_status", {29'd0, bus.frm_status},  32'd1);
      check("t2_hold_err",    {28'd0, bus.frm_err_cnt}, 32'd3);

      // ---------------- 3a: bm_fail -> UNCORR --------------------------------
      snap();
      send_frame(63, -1, 0);
      wait_bm(10, c);
      check("t3a_bm_latency", c, 32'd3);
      pulse_bm(1, 1'b1, 4'd0);
      check("t3a_frm_done", {31'd0, bus.frm_done},    32'd1);
      check("t3a_status",   {29'd0, bus.frm_status},  32'd2);
      check("t3a_err_cnt",  {28'd0, bus.frm_err_cnt}, 32'd0);
      check("t3a_no_chien", n_chs - b_chs, 32'd0);
      bus.bm_fail = 1'b0;

      // ---------------- 3b: deg 5, roots 4 -> UNCORR -------------------------
      send_frame(63, -1, 0);
      wait_bm(10, c);
      pulse_bm(0, 1'b0, 4'd5);
      check("t3b_chien_start", {31'd0, bus.chien_start}, 32'd1);
      pulse_chien(0, 4'd4);
      check("t3b_frm_done", {31'd0, bus.frm_done},    32'd1);
      check("t3b_status",   {29'd0, bus.frm_status},  32'd2);
      check("t3b_err_cnt",  {28'd0, bus.frm_err_cnt}, 32'd0);

      // ---------------- 4a: eop on beat 10 -> FRAME_ERR ----------------------
      bus.synd_zero = 1'b1;
      snap();
      send_frame(10, -1, 0);
      wait_done(5, c);
      check("t4a_latency", c, 32'd1);
      check("t4a_status",  {29'd0, bus.frm_status}, 32'd3);
      check("t4a_en_cnt",  n_en - b_en, 32'd10);

      // ---------------- 4b: sop on beat 20 -> FRAME_ERR ----------------------
      snap();
      send_frame(63, 20, 0);
      wait_done(5, c);
      check("t4b_latency", c, 32'd1);
      check("t4b_status",  {29'd0, bus.frm_status}, 32'd3);
      check("t4b_en_cnt",  n_en - b_en, 32'd20);

      // ---------------- 4c: sop+eop on one beat -> FRAME_ERR -----------------
      snap();
      send_frame(0, -1, 0);
      wait_done(5, c);
      check("t4c_latency", c, 32'd1);
      check("t4c_status",  {29'd0, bus.frm_status}, 32'd3);
      check("t4c_en_cnt",  n_en - b_en,   32'd0);
      check("t4c_clr_cnt", n_clr - b_clr, 32'd0);

      // ---------------- 4d: valid frame with gaps -> OK ----------------------
      snap();
      send_frame(63, -1, 5);
      wait_done(10, c);
      check("t4d_latency", c, 32'd3);
      check("t4d_status",  {29'd0, bus.frm_status},  32'd0);
      check("t4d_err_cnt", {28'd0, bus.frm_err_cnt}, 32'd0);
      check("t4d_en_cnt",  n_en - b_en, 32'd64);
      check("t4d_bad",     n_bad - b_bad, 32'd0);

      // ---------------- 5a: BM never finishes -> TIMEOUT ---------------------
      bus.synd_zero = 1'b0;
      snap();
      send_frame(63, -1, 0);
      wait_bm(10, c);
      wait_done(1100, c);
      check("t5a_tmo_cycles", c, 32'd1024);
      check("t5a_status",  {29'd0, bus.frm_status},  32'd4);
      check("t5a_err_cnt", {28'd0, bus.frm_err_cnt}, 32'd0);
      check("t5a_no_chien", n_chs - b_chs, 32'd0);

      // ---------------- 5b: bm_done on BM cycle 1024 -> normal ---------------
      send_frame(63, -1, 0);
      wait_bm(10, c);
      pulse_bm(1023, 1'b0, 4'd2);
      check("t5b_chien_start", {31'd0, bus.chien_start}, 32'd1);
      check("t5b_no_done",     {31'd0, bus.frm_done},    32'd0);
      pulse_chien(1, 4'd2);
      check("t5b_frm_done", {31'd0, bus.frm_done},    32'd1);
      check("t5b_status",   {29'd0, bus.frm_status},  32'd1);
      check("t5b_err_cnt",  {28'd0, bus.frm_err_cnt}, 32'd2);

      // ---------------- 5c: Chien never finishes -> TIMEOUT ------------------
      send_frame(63, -1, 0);
      wait_bm(10, c);
      pulse_bm(0, 1'b0, 4'd6);
      check("t5c_chien_start", {31'd0, bus.chien_start}, 32'd1);
      wait_done(1100, c);
      check("t5c_tmo_cycles", c, 32'd1024);
      check("t5c_status", {29'd0, bus.frm_status}, 32'd4);

      // ---------------- 6: reset mid-frame, stray traffic, recovery ----------
      snap();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_sop   = (i == 0);
         bus.in_eop   = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #3;
      check("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("t6_rst_synd_en",  {31'd0, bus.synd_en},  32'd0);
      check("t6_rst_frm_done", {31'd0, bus.frm_done}, 32'd0);
      check("t6_rst_status",   {29'd0, bus.frm_status}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.in_valid   = (i % 2 == 0);
         bus.in_sop     = 1'b0;
         bus.in_eop     = (i == 4);
         bus.bm_done    = (i == 1);
         bus.chien_done = (i == 3);
         #3;
         check("t6_stray_en", {31'd0, bus.synd_en}, 32'd0);
      end
      @(negedge clk);
      idle();
      #3;
      check("t6_en_cnt",   n_en - b_en,     32'd30);
      check("t6_clr_cnt",  n_clr - b_clr,   32'd1);
      check("t6_done_cnt", n_done - b_done, 32'd0);
      check("t6_bm_cnt",   n_bms - b_bms,   32'd0);
      check("t6_chs_cnt",  n_chs - b_chs,   32'd0);
      bus.synd_zero = 1'b1;
      send_frame(63, -1, 7);
      wait_done(10, c);
      check("t6_latency", c, 32'd3);
      check("t6_status",  {29'd0, bus.frm_status}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
`default_nettype wire
